// File: rtl/ins_fetch_pkg.sv
// Shared types, opcode constants and prediction helpers for the instruction fetch unit.
package ins_fetch_pkg;

    // Branch history table geometry: BHT_SIZE entries indexed by BHT_R pc bits (pc[5:2]).
    localparam int BHT_SIZE = 16;
    localparam int BHT_R    = 4;

    // RV32 opcodes that change control flow.
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT_MEM,
        ST_HOLD,
        ST_WAIT_JALR,
        ST_DROP
    } fetch_state_t;

    // Outcome of predicting one fetched word.
    typedef struct packed {
        logic        jmp;      // predicted taken branch or jal
        logic        is_jalr;  // fetch must wait for the ROB to supply the target
        logic [31:0] next_pc;  // pc the fetcher continues from
        logic [31:0] another;  // the path not chosen
    } pred_t;

    function automatic logic [31:0] imm_b(input logic [31:0] word);
        return {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] word);
        return {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    endfunction

    function automatic pred_t predict(input logic [31:0] pc, input logic [31:0] word,
                                      input logic bht_taken);
        pred_t       p;
        logic [31:0] seq;
        seq       = pc + 32'd4;
        p.jmp     = 1'b0;
        p.is_jalr = 1'b0;
        p.next_pc = seq;
        p.another = seq;
        case (word[6:0])
            OP_BRANCH: begin
                if (bht_taken) begin
                    p.jmp     = 1'b1;
                    p.next_pc = pc + imm_b(word);
                end else begin
                    p.another = pc + imm_b(word);
                end
            end
            OP_JAL: begin
                p.jmp     = 1'b1;
                p.next_pc = pc + imm_j(word);
            end
            OP_JALR: begin
                p.is_jalr = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// Instruction-cache request/response bus between the fetcher and the icache.
interface ins_fetch_if;
    logic        ic_req;    // level request, held until ic_valid
    logic [31:0] ic_addr;   // stable while ic_req is high
    logic        ic_valid;  // one-cycle response pulse
    logic [31:0] ic_data;   // instruction word, valid with ic_valid

    modport master (output ic_req, output ic_addr, input ic_valid, input ic_data);
    modport slave  (input ic_req, input ic_addr, output ic_valid, output ic_data);
endinterface

// File: rtl/ins_fetch_bht.sv
// Branch history table: 2-bit saturating counters, one lookup port and one update port.
// A lookup and an update of the same entry in one cycle returns the pre-update value.
module ins_fetch_bht
    import ins_fetch_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic [BHT_R-1:0] lookup_idx,
    output logic             lookup_taken,
    input  logic             upd_en,
    input  logic [BHT_R-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] cnt_reg  [BHT_SIZE];
    logic [1:0] cnt_next [BHT_SIZE];

    // Per-entry saturating increment/decrement when the update targets this entry.
    generate
        for (genvar gi = 0; gi < BHT_SIZE; gi++) begin : g_cnt
            assign cnt_next[gi] =
                !(upd_en && (upd_idx == BHT_R'(gi))) ? cnt_reg[gi] :
                upd_taken ? ((cnt_reg[gi] == 2'b11) ? 2'b11 : cnt_reg[gi] + 2'b01)
                          : ((cnt_reg[gi] == 2'b00) ? 2'b00 : cnt_reg[gi] - 2'b01);
        end
    endgenerate

    // Counter storage; every entry starts weakly not-taken.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_SIZE; i++) cnt_reg[i] <= 2'b01;
        end else if (rdy_in) begin
            for (int i = 0; i < BHT_SIZE; i++) cnt_reg[i] <= cnt_next[i];
        end
    end

    assign lookup_taken = cnt_reg[lookup_idx][1];

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: issues icache requests, buffers one word, predicts the next pc
// with a small BHT, and offers the word to decode under backpressure and flushes.
module ins_fetch
    import ins_fetch_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    ins_fetch_if.master ic,
    input  logic        f_stall,
    output logic        is_ins,
    output logic [31:0] ins_addr,
    output logic [31:0] ins,
    output logic        pred_jmp,
    output logic [31:0] pred_another,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    input  logic        br_upd,
    input  logic [31:0] br_upd_pc,
    input  logic        br_upd_taken
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         buf_valid_reg, buf_valid_next;
    logic [31:0]  ins_reg, ins_next;
    logic [31:0]  ins_addr_reg, ins_addr_next;
    logic         pred_jmp_reg, pred_jmp_next;
    logic [31:0]  pred_another_reg, pred_another_next;
    logic [31:0]  next_pc_reg, next_pc_next;
    logic         is_jalr_reg, is_jalr_next;
    logic         ic_req_reg, ic_req_next;
    logic [31:0]  ic_addr_reg, ic_addr_next;

    logic         bht_taken;
    pred_t        pred;

    // Only the index bits of the committed branch pc select a counter.
    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^{br_upd_pc[31:6], br_upd_pc[1:0]};

    ins_fetch_bht u_bht (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .lookup_idx   (pc_reg[5:2]),
        .lookup_taken (bht_taken),
        .upd_en       (br_upd),
        .upd_idx      (br_upd_pc[5:2]),
        .upd_taken    (br_upd_taken)
    );

    assign pred = predict(pc_reg, ic.ic_data, bht_taken);

    // Next-state and datapath decisions; everything holds unless a case below moves it.
    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        buf_valid_next    = buf_valid_reg;
        ins_next          = ins_reg;
        ins_addr_next     = ins_addr_reg;
        pred_jmp_next     = pred_jmp_reg;
        pred_another_next = pred_another_reg;
        next_pc_next      = next_pc_reg;
        is_jalr_next      = is_jalr_reg;
        ic_req_next       = ic_req_reg;
        ic_addr_next      = ic_addr_reg;

        is_ins = rdy_in && (state_reg == ST_HOLD) && buf_valid_reg && !f_stall && !rob_clear;

        if (rdy_in) begin
            if (rob_clear) begin
                pc_next        = rob_new_pc;
                buf_valid_next = 1'b0;
            end
            case (state_reg)
                ST_FETCH: begin
                    if (!rob_clear) begin
                        ic_req_next  = 1'b1;
                        ic_addr_next = pc_reg;
                        state_next   = ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    if (ic.ic_valid) begin
                        ic_req_next = 1'b0;
                        if (rob_clear) begin
                            state_next = ST_FETCH;
                        end else begin
                            buf_valid_next    = 1'b1;
                            ins_next          = ic.ic_data;
                            ins_addr_next     = pc_reg;
                            pred_jmp_next     = pred.jmp;
                            pred_another_next = pred.another;
                            next_pc_next      = pred.next_pc;
                            is_jalr_next      = pred.is_jalr;
                            state_next        = ST_HOLD;
                        end
                    end else if (rob_clear) begin
                        state_next = ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (rob_clear) begin
                        state_next = ST_FETCH;
                    end else if (is_ins) begin
                        buf_valid_next = 1'b0;
                        pc_next        = next_pc_reg;
                        state_next     = is_jalr_reg ? ST_WAIT_JALR : ST_FETCH;
                    end
                end
                ST_WAIT_JALR: begin
                    if (rob_clear) state_next = ST_FETCH;
                end
                ST_DROP: begin
                    if (ic.ic_valid) begin
                        ic_req_next = 1'b0;
                        state_next  = ST_FETCH;
                    end
                end
                default: state_next = ST_FETCH;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg        <= ST_FETCH;
            pc_reg           <= 32'd0;
            buf_valid_reg    <= 1'b0;
            ins_reg          <= 32'd0;
            ins_addr_reg     <= 32'd0;
            pred_jmp_reg     <= 1'b0;
            pred_another_reg <= 32'd0;
            next_pc_reg      <= 32'd0;
            is_jalr_reg      <= 1'b0;
            ic_req_reg       <= 1'b0;
            ic_addr_reg      <= 32'd0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            buf_valid_reg    <= buf_valid_next;
            ins_reg          <= ins_next;
            ins_addr_reg     <= ins_addr_next;
            pred_jmp_reg     <= pred_jmp_next;
            pred_another_reg <= pred_another_next;
            next_pc_reg      <= next_pc_next;
            is_jalr_reg      <= is_jalr_next;
            ic_req_reg       <= ic_req_next;
            ic_addr_reg      <= ic_addr_next;
        end
    end

    assign ic.ic_req    = ic_req_reg;
    assign ic.ic_addr   = ic_addr_reg;
    assign ins          = ins_reg;
    assign ins_addr     = ins_addr_reg;
    assign pred_jmp     = pred_jmp_reg;
    assign pred_another = pred_another_reg;

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 clk_in  input  1  system clock; all state on posedge.
REQ-002 rst_in  input  1  reset, asynchronous, active-high.
REQ-003 rdy_in  input  1  global enable; low holds all state (async reset still acts).
REQ-004 ic_req  output  1  icache request, level, held until ic_valid.
REQ-005 ic_addr  output  32  fetch address, stable while ic_req high.
REQ-006 ic_valid  input  1  one-cycle response pulse.
REQ-007 ic_data  input  32  instruction word, valid with ic_valid.
REQ-008 f_stall  input  1  decode backpressure (rs/lsb/rob full).
REQ-009 is_ins  output  1  instruction offered to decode this cycle.
REQ-010 ins_addr, ins  output  32 each  PC and word of the offered instruction.
REQ-011 pred_jmp  output  1  predicted taken (branch) or jal.
REQ-012 pred_another  output  32  the not-chosen next PC.
REQ-013 rob_clear  input  1  misprediction/jalr flush.
REQ-014 rob_new_pc  input  32  restart PC, valid with rob_clear.
REQ-015 br_upd  input  1  branch commit pulse.
REQ-016 br_upd_pc  input  32  PC of committed branch.
REQ-017 br_upd_taken  input  1  actual branch outcome.

Function
REQ-018 States: FETCH, WAIT_MEM, HOLD, WAIT_JALR, DROP.
REQ-019 FETCH: ic_req=1, ic_addr=pc; next state WAIT_MEM.
REQ-020 WAIT_MEM: on ic_valid latch {pc, ic_data} into buffer, compute prediction, go HOLD.
REQ-021 HOLD: is_ins = buffer valid && !f_stall && !rob_clear (combinational); accepted on that edge; then FETCH at next pc, or WAIT_JALR if opcode jalr.
REQ-022 Next pc: branch (opcode 1100011) taken-predicted -> pc+immB, pred_another=pc+4; not-taken -> pc+4, pred_another=pc+immB.
REQ-023 jal: next pc = pc+immJ, pred_jmp=1, pred_another=pc+4.
REQ-024 jalr: pred_jmp=0, pred_another=pc+4; fetch stops in WAIT_JALR until rob_clear.
REQ-025 Other opcodes: next pc = pc+4, pred_jmp=0, pred_another=pc+4.
REQ-026 Immediates sign-extended to 32 bits; all additions modulo 2^32.
REQ-027 BHT: 16 two-bit saturating counters indexed pc[5:2]; taken iff counter[1]=1.
REQ-028 br_upd: counter at br_upd_pc[5:2] increments (taken) or decrements (not taken), saturating at 3/0.
REQ-029 Same-cycle lookup and update to one entry: lookup sees old value.
REQ-030 rob_clear in any state: pc <= rob_new_pc, buffer invalidated, is_ins forced 0 that cycle.
REQ-031 rob_clear while a request is outstanding (WAIT_MEM, or FETCH with ic_req high): go DROP; next ic_valid discarded; then FETCH at the new pc.
REQ-032 rob_clear coinciding with ic_valid: response discarded, state FETCH directly.
REQ-033 f_stall high indefinitely: buffer and outputs held stable, no new ic_req.
REQ-034 Throughput: at most one instruction per icache response; latency ic_valid -> is_ins = 1 cycle.

Reset
REQ-035 On rst_in: pc=0, state FETCH, buffer invalid, is_ins=0, ic_req=0, pred_jmp=0, pred_another=0, ins=0, ins_addr=0, all BHT counters = 01.
REQ-036 Reset mid-request: in-flight icache response after reset is ignored (icache is reset by the same rst_in).

Structure
REQ-037 Opcode constants (`ob, `ojal, `ojalr) and new `BHT_SIZE, `BHT_R defines live in const.v.
REQ-038 One sub-module: bht (counter table, lookup port + update port).

Verification
REQ-039 Straight-line: words at 0x0,0x4,0x8 -> is_ins with ins_addr 0x0,0x4,0x8, pred_jmp=0.
REQ-040 Branch at 0x10, imm +0x20, counter reset 01 -> next fetch 0x14, pred_another=0x30; after two br_upd taken -> next fetch 0x30, pred_another=0x14.
REQ-041 jal at 0x8, imm -8 -> next ic_addr 0x0, pred_jmp=1, pred_another=0xC.
REQ-042 jalr at 0x20 -> no ic_req until rob_clear with rob_new_pc=0x100 -> ic_addr=0x100.
REQ-043 f_stall high 5 cycles with buffer valid -> is_ins=0, ins stable; release -> single is_ins pulse.
REQ-044 rob_clear (new pc 0x40) during WAIT_MEM -> following ic_valid dropped, next ic_addr=0x40.
